portout: RTL and testbench

- Serial transmitter for the 8x8 switch's per-port bit-serial framing protocol; the mirror of the input-port deserializer.
- Accepts one parallel packet (4-bit destination address + 32-bit payload) from the switch fabric/arbiter side.
- Serializes it onto frame_n / valid_n / dout in exactly the format the input port consumes.
- One instance per output port; also used as the stimulus source in loopback benches.

---
 rtl/switch_defs.sv | 16 +
 rtl/portout_piso.sv | 39 +++
 rtl/portout.sv | 126 ++++++++++++
 tb/tb_portout.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_defs.sv
// Shared constants and FSM encoding for the 8x8 switch serial port blocks.
package switch_defs;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 32;
  localparam int PORTS     = 8;
  localparam int FRAME_LEN = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/portout_piso.sv
// Parallel-in serial-out shifter; LSB is the serial output, zeros fill from the top.
module portout_piso #(
  parameter int W = 36
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         lsb
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  // Load wins over shift; zero fill keeps dout at 0 once the frame has drained.
  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[W-1:1]};
    end else begin
      sh_d = sh_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= {W{1'b0}};
    end else begin
      sh_q <= sh_d;
    end
  end

  assign lsb = sh_q[0];

endmodule

// File: rtl/portout.sv
// Output-port serializer: sends {addr, payload} LSB-first on frame_n/valid_n/dout.
module portout
  import switch_defs::*;
#(
  parameter int GAP = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              send,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] payload,
  output logic              ready,
  output logic              frame_n,
  output logic              valid_n,
  output logic              dout,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             frame_n_q;
  logic             frame_n_d;
  logic             valid_n_q;
  logic             valid_n_d;
  logic             done_q;
  logic             done_d;
  logic             load_s;
  logic             shift_s;

  // Next state, bit count and the flopped line values for the upcoming cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          state_d = ST_ADDR;
          cnt_d   = {CNT_W{1'b0}};
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        shift_s = 1'b1;
        if (cnt_q == ADDR_LAST) begin
          state_d = ST_DATA;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        shift_s = 1'b1;
        if (cnt_q == DATA_LAST) begin
          state_d = ST_GAP;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // frame_n releases on the final payload bit so the receiver sees the end in-band.
    frame_n_d = !((state_d == ST_ADDR) ||
                  ((state_d == ST_DATA) && (cnt_d != DATA_LAST)));
    valid_n_d = (state_d != ST_DATA);
    done_d    = (state_d == ST_DATA) && (cnt_d == DATA_LAST);
  end

  // State, counter and registered line outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      frame_n_q <= 1'b1;
      valid_n_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_n_q <= frame_n_d;
      valid_n_q <= valid_n_d;
      done_q    <= done_d;
    end
  end

  portout_piso #(
    .W(FRAME_LEN)
  ) u_piso (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (load_s),
    .shift  (shift_s),
    .din    ({payload, addr}),
    .lsb    (dout)
  );

  assign ready   = (state_q == ST_IDLE);
  assign frame_n = frame_n_q;
  assign valid_n = valid_n_q;
  assign done    = done_q;

endmodule

// File: tb/tb_portout.sv
// Bench for portout: cycle-accurate expected-trace model, bench-side receiver, directed corners.
module tb_portout;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        send;
  logic [3:0]  addr;
  logic [31:0] payload;
  logic        ready, frame_n, valid_n, dout, done;

  logic        send3;
  logic [3:0]  addr3;
  logic [31:0] payload3;
  logic        ready3, frame_n3, valid_n3, dout3, done3;

  portout #(.GAP(1)) dut (
    .clock(clock), .reset_n(reset_n), .send(send), .addr(addr), .payload(payload),
    .ready(ready), .frame_n(frame_n), .valid_n(valid_n), .dout(dout), .done(done)
  );

  portout #(.GAP(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .send(send3), .addr(addr3), .payload(payload3),
    .ready(ready3), .frame_n(frame_n3), .valid_n(valid_n3), .dout(dout3), .done(done3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected line tuples {ready, frame_n, valid_n, dout, done}
  localparam logic [4:0] IDLE_T = 5'b11100;
  localparam logic [4:0] GAP_T  = 5'b01100;

  logic [4:0] exp_q[$];
  logic [4:0] exp_t;
  logic [4:0] act_t;
  logic       chk_en = 1'b0;
  logic       model_idle = 1'b1;

  // Trace checker: every cycle the DUT must show exactly the next expected tuple
  always @(negedge clock) begin
    if (chk_en) begin
      if (!reset_n) begin
        exp_q.delete();
        exp_t = IDLE_T;
      end else if (exp_q.size() > 0) begin
        exp_t = exp_q.pop_front();
      end else begin
        exp_t = IDLE_T;
      end
      model_idle = exp_t[4];
      act_t = {ready, frame_n, valid_n, dout, done};
      checks++;
      if (act_t !== exp_t) begin
        errors++;
        $display("FAIL trace cyc=%0d got rdy/fn/vn/dout/done=%b want %b", cyc, act_t, exp_t);
      end
    end
  end

  // Model: an accepted packet becomes 36 frame cycles plus one gap cycle
  always @(posedge clock) begin
    if (reset_n && chk_en && model_idle && send) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 1'b0, 1'b1, addr[k], 1'b0});
      for (int k = 0; k < 32; k++) exp_q.push_back({1'b0, (k == 31), 1'b0, payload[k], (k == 31)});
      exp_q.push_back(GAP_T);
      model_idle = 1'b0;
    end
  end

  // Bench-side deserializer mirroring the input port
  logic [3:0]  rx_a_sh = 4'd0;
  logic [31:0] rx_p_sh = 32'd0;
  logic [3:0]  rx_addr = 4'd0;
  logic [31:0] rx_payload = 32'd0;
  int na = 0, np = 0, rx_na = 0, rx_np = 0, rx_cnt = 0, done_cnt = 0;

  always @(negedge clock) begin
    if (done) done_cnt <= done_cnt + 1;
    if (!reset_n) begin
      na <= 0;
      np <= 0;
    end else if (!frame_n && valid_n) begin
      rx_a_sh <= {dout, rx_a_sh[3:1]};
      na <= na + 1;
    end else if (!valid_n) begin
      if (frame_n) begin
        rx_addr    <= rx_a_sh;
        rx_payload <= {dout, rx_p_sh[31:1]};
        rx_na      <= na;
        rx_np      <= np + 1;
        rx_cnt     <= rx_cnt + 1;
        na <= 0;
        np <= 0;
      end else begin
        rx_p_sh <= {dout, rx_p_sh[31:1]};
        np <= np + 1;
      end
    end
  end

  // Frame-start and gap-length recorders for the back-to-back test
  logic rec_en = 1'b0;
  logic prev_fn = 1'b1, prev_fn3 = 1'b1;
  int fall_q[$];
  int fall3_q[$];
  int gap3_q[$];
  int gap_run = 0;

  always @(negedge clock) begin
    prev_fn  <= frame_n;
    prev_fn3 <= frame_n3;
    if (rec_en) begin
      if (prev_fn && !frame_n) fall_q.push_back(cyc);
      if (prev_fn3 && !frame_n3) fall3_q.push_back(cyc);
      if (!ready3 && frame_n3 && valid_n3) begin
        gap_run <= gap_run + 1;
      end else if (gap_run > 0) begin
        gap3_q.push_back(gap_run);
        gap_run <= 0;
      end
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    while (rx_cnt < target && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_int("rx_frame_arrived", (rx_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
  endtask

  task automatic send_pkt(input logic [3:0] a, input logic [31:0] p);
    @(negedge clock);
    addr = a;
    payload = p;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] payload;
    logic [3:0]  exp_addr;
    logic [31:0] exp_payload;
  } vec_t;

  vec_t vec[6];

  initial begin
    int base, dbase, n;
    vec[0] = '{4'hA, 32'hDEADBEEF, 4'hA, 32'hDEADBEEF};
    vec[1] = '{4'h3, 32'h0000_0001, 4'h3, 32'h0000_0001};
    vec[2] = '{4'h7, 32'h8000_0000, 4'h7, 32'h8000_0000};
    vec[3] = '{4'hF, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
    vec[4] = '{4'h0, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vec[5] = '{4'h5, 32'h1234_5678, 4'h5, 32'h1234_5678};

    reset_n = 1'b0;
    send = 1'b0; addr = 4'd0; payload = 32'd0;
    send3 = 1'b0; addr3 = 4'h2; payload3 = 32'hCAFE_F00D;
    chk_en = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);

    // Directed packets through the bench receiver
    for (int i = 0; i < 6; i++) begin
      base = rx_cnt;
      dbase = done_cnt;
      send_pkt(vec[i].addr, vec[i].payload);
      wait_rx(base + 1);
      check_int("rx_addr", int'(rx_addr), int'(vec[i].exp_addr));
      checks++;
      if (rx_payload !== vec[i].exp_payload) begin
        errors++;
        $display("FAIL rx_payload got %h want %h", rx_payload, vec[i].exp_payload);
      end
      check_int("rx_addr_bits", rx_na, 4);
      check_int("rx_payload_bits", rx_np, 32);
      @(negedge clock);
      check_int("done_pulses", done_cnt - dbase, 1);
      wait_ready();
    end

    // New request and changed inputs mid-frame must be ignored
    base = rx_cnt;
    send_pkt(4'h9, 32'h0F0F_1234);
    repeat (8) @(negedge clock);
    addr = 4'hC; payload = 32'h5555_AAAA; send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    wait_rx(base + 1);
    check_int("midframe_addr", int'(rx_addr), 9);
    checks++;
    if (rx_payload !== 32'h0F0F_1234) begin
      errors++;
      $display("FAIL midframe_payload got %h want %h", rx_payload, 32'h0F0F_1234);
    end
    repeat (45) @(negedge clock);
    check_int("midframe_single_frame", rx_cnt - base, 1);

    // Back-to-back with send held: 38 cycles (GAP=1), 40 cycles (GAP=3)
    fall_q.delete(); fall3_q.delete(); gap3_q.delete();
    rec_en = 1'b1;
    @(negedge clock);
    addr = 4'h6; payload = 32'hA5A5_0FF0; send = 1'b1; send3 = 1'b1;
    repeat (125) @(negedge clock);
    send = 1'b0; send3 = 1'b0;
    repeat (50) @(negedge clock);
    rec_en = 1'b0;
    check_int("b2b_frames", (fall_q.size() >= 3) ? 1 : 0, 1);
    if (fall_q.size() >= 3) begin
      check_int("b2b_spacing_0", fall_q[1] - fall_q[0], 38);
      check_int("b2b_spacing_1", fall_q[2] - fall_q[1], 38);
    end
    check_int("gap3_frames", (fall3_q.size() >= 3) ? 1 : 0, 1);
    if (fall3_q.size() >= 3) begin
      check_int("gap3_spacing_0", fall3_q[1] - fall3_q[0], 40);
      check_int("gap3_spacing_1", fall3_q[2] - fall3_q[1], 40);
    end
    check_int("gap3_runs", (gap3_q.size() >= 2) ? 1 : 0, 1);
    foreach (gap3_q[j]) check_int("gap3_len", gap3_q[j], 3);

    // Async reset at payload bit 12, then a clean frame
    wait_ready();
    send_pkt(4'hB, 32'hF00D_A5A5);
    n = 0;
    while (valid_n && n < 60) begin
      @(negedge clock);
      n++;
    end
    check_int("reach_data", valid_n ? 0 : 1, 1);
    repeat (12) @(negedge clock);
    chk_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({ready, frame_n, valid_n, dout, done} !== IDLE_T) begin
      errors++;
      $display("FAIL async_reset got %b want %b", {ready, frame_n, valid_n, dout, done}, IDLE_T);
    end
    @(negedge clock);
    #1 reset_n = 1'b1;
    exp_q.delete();
    model_idle = 1'b1;
    chk_en = 1'b1;
    base = rx_cnt;
    send_pkt(4'h6, 32'h1357_9BDF);
    wait_rx(base + 1);
    check_int("post_reset_addr", int'(rx_addr), 6);
    check_int("post_reset_addr_bits", rx_na, 4);
    checks++;
    if (rx_payload !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL post_reset_payload got %h want %h", rx_payload, 32'h1357_9BDF);
    end
    wait_ready();

    // Randomized traffic against the trace model
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      send = ($urandom_range(0, 9) == 0);
      addr = 4'($urandom);
      payload = $urandom;
    end
    send = 1'b0;
    repeat (45) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
